// File: rtl/uart_8250_rx.sv
// ---------------------------------------------------------------------------
// uart_8250_rx
//
// Serial receive front end of an 8250-compatible UART. The asynchronous RX
// line is synchronised, oversampled 16x from the shared baud divisor, and
// deframed (5..8 data bits, optional parity, first stop bit checked). Each
// character and its error flags land in a one-entry holding register that
// is drained over a valid/ready handshake.
//
// Ports
//   CLK_I      in   1   system clock
//   RST_I      in   1   asynchronous active-high reset
//   RX_I       in   1   serial line (idle 1), asynchronous to CLK_I
//   DIVISOR_I  in  16   clocks per oversample tick (0 behaves as 1)
//   LCR_I      in   5   [1:0] word length 5..8, [3] parity enable,
//                       [4] even parity, [2] ignored
//   DATA_O     out  8   received character, LSB aligned, upper bits 0
//   PE_O       out  1   parity error for DATA_O
//   FE_O       out  1   framing error (stop bit sampled 0)
//   BI_O       out  1   break indication for DATA_O
//   VALID_O    out  1   holding register full
//   READY_I    in   1   consumer accepts when VALID_O & READY_I
//   OE_O       out  1   one-clock pulse when a completed frame is dropped
//   BUSY_O     out  1   receiver FSM not idle
// ---------------------------------------------------------------------------
module uart_8250_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        RX_I,
    input  logic [15:0] DIVISOR_I,
    input  logic [4:0]  LCR_I,
    output logic [7:0]  DATA_O,
    output logic        PE_O,
    output logic        FE_O,
    output logic        BI_O,
    output logic        VALID_O,
    input  logic        READY_I,
    output logic        OE_O,
    output logic        BUSY_O
);

    // Last oversample tick of a bit; the mid-bit sample points 7/8/9 are
    // fixed and assume 16 ticks per bit.
    localparam logic [3:0] OS_LAST = 4'(OVERSAMPLE - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_START   = 3'd1;
    localparam logic [2:0] ST_DATA    = 3'd2;
    localparam logic [2:0] ST_PARITY  = 3'd3;
    localparam logic [2:0] ST_STOP    = 3'd4;
    localparam logic [2:0] ST_BRKWAIT = 3'd5;

    // LCR bit 2 (stop-bit count) does not matter to the receiver.
    logic lcr_unused;
    assign lcr_unused = LCR_I[2];

    // -----------------------------------------------------------------------
    // Two-flop synchroniser, idle level 1
    // -----------------------------------------------------------------------
    logic rx_meta_reg;
    logic rx_s_reg;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
        end else begin
            rx_meta_reg <= RX_I;
            rx_s_reg    <= rx_meta_reg;
        end
    end

    // -----------------------------------------------------------------------
    // Oversample tick generator
    // -----------------------------------------------------------------------
    logic [2:0]  state_reg;
    logic [2:0]  state_next;
    logic [15:0] tick_cnt_reg;
    logic [15:0] div_max;
    logic        tick;
    logic        start_det;

    assign div_max   = (DIVISOR_I == 16'd0) ? 16'd0 : (DIVISOR_I - 16'd1);
    // ">=" rather than "==" so that lowering the divisor while the counter
    // is above the new limit wraps at once instead of running 64k clocks.
    assign tick      = (tick_cnt_reg >= div_max);
    assign start_det = (state_reg == ST_IDLE) && !rx_s_reg;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            tick_cnt_reg <= 16'd0;
        end else if (start_det || tick) begin
            // Clearing on the start edge aligns the bit grid to the edge.
            tick_cnt_reg <= 16'd0;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + 16'd1;
        end
    end

    // -----------------------------------------------------------------------
    // Deframing FSM
    // -----------------------------------------------------------------------
    logic [3:0] os_cnt_reg,  os_cnt_next;
    logic [2:0] bit_cnt_reg, bit_cnt_next;
    logic [7:0] shift_reg,   shift_next;
    logic       par_bit_reg, par_bit_next;
    logic       pe_reg,      pe_next;
    logic       samp7_reg,   samp7_next;
    logic       samp8_reg,   samp8_next;
    logic [1:0] wlen_reg,    wlen_next;
    logic       par_en_reg,  par_en_next;
    logic       even_reg,    even_next;

    logic       vote;
    logic       mid_tick;
    logic       end_tick;
    logic [2:0] last_bit;
    logic       par_calc;
    logic       frame_done;
    logic       fe_now;
    logic       bi_now;

    // 2-of-3 majority of the samples at os_cnt 7, 8 and the live one at 9.
    assign vote     = (samp7_reg & samp8_reg) | (samp7_reg & rx_s_reg) |
                      (samp8_reg & rx_s_reg);
    assign mid_tick = tick && (os_cnt_reg == 4'd9);
    assign end_tick = tick && (os_cnt_reg == OS_LAST);
    // Word length 5..8 means the last data bit index is 4 + wlen.
    assign last_bit = {1'b1, wlen_reg};
    // XOR over data and received parity bit: 0 when the count of 1s is even.
    assign par_calc = (^shift_reg) ^ vote;

    always_comb begin
        state_next   = state_reg;
        os_cnt_next  = os_cnt_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        par_bit_next = par_bit_reg;
        pe_next      = pe_reg;
        samp7_next   = samp7_reg;
        samp8_next   = samp8_reg;
        wlen_next    = wlen_reg;
        par_en_next  = par_en_reg;
        even_next    = even_reg;
        frame_done   = 1'b0;
        fe_now       = 1'b0;
        bi_now       = 1'b0;

        // Bit-time bookkeeping shared by every state that walks a bit.
        if ((state_reg != ST_IDLE) && (state_reg != ST_BRKWAIT) && tick) begin
            os_cnt_next = os_cnt_reg + 4'd1;
            if (os_cnt_reg == 4'd7) begin
                samp7_next = rx_s_reg;
            end
            if (os_cnt_reg == 4'd8) begin
                samp8_next = rx_s_reg;
            end
        end

        case (state_reg)
            ST_IDLE: begin
                if (!rx_s_reg) begin
                    // Latch the line format so a mid-frame LCR write is
                    // harmless; clear per-frame state so unused data bits
                    // read back as 0 and PE stays 0 without parity.
                    state_next   = ST_START;
                    os_cnt_next  = 4'd0;
                    bit_cnt_next = 3'd0;
                    shift_next   = 8'd0;
                    par_bit_next = 1'b0;
                    pe_next      = 1'b0;
                    wlen_next    = LCR_I[1:0];
                    par_en_next  = LCR_I[3];
                    even_next    = LCR_I[4];
                end
            end

            ST_START: begin
                if (mid_tick && vote) begin
                    // Line back high mid start bit: noise, not a frame.
                    state_next = ST_IDLE;
                end else if (end_tick) begin
                    state_next = ST_DATA;
                end
            end

            ST_DATA: begin
                if (mid_tick) begin
                    shift_next[bit_cnt_reg] = vote;
                end
                if (end_tick) begin
                    if (bit_cnt_reg == last_bit) begin
                        state_next = par_en_reg ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                    end
                end
            end

            ST_PARITY: begin
                if (mid_tick) begin
                    par_bit_next = vote;
                    // Even parity expects XOR 0, odd parity expects XOR 1.
                    pe_next      = (par_calc != ~even_reg);
                end
                if (end_tick) begin
                    state_next = ST_STOP;
                end
            end

            ST_STOP: begin
                // The frame is complete at the stop-bit centre; the second
                // half is not waited out so back-to-back frames still work.
                if (mid_tick) begin
                    frame_done = 1'b1;
                    fe_now     = ~vote;
                    bi_now     = ~vote && (shift_reg == 8'd0) &&
                                 (!par_en_reg || !par_bit_reg);
                    state_next = bi_now ? ST_BRKWAIT : ST_IDLE;
                end
            end

            ST_BRKWAIT: begin
                // A break reports one character; hold off until the line
                // is released so the low level is not seen as new starts.
                if (rx_s_reg) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_reg   <= ST_IDLE;
            os_cnt_reg  <= 4'd0;
            bit_cnt_reg <= 3'd0;
            shift_reg   <= 8'd0;
            par_bit_reg <= 1'b0;
            pe_reg      <= 1'b0;
            samp7_reg   <= 1'b1;
            samp8_reg   <= 1'b1;
            wlen_reg    <= 2'd0;
            par_en_reg  <= 1'b0;
            even_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            os_cnt_reg  <= os_cnt_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            par_bit_reg <= par_bit_next;
            pe_reg      <= pe_next;
            samp7_reg   <= samp7_next;
            samp8_reg   <= samp8_next;
            wlen_reg    <= wlen_next;
            par_en_reg  <= par_en_next;
            even_reg    <= even_next;
        end
    end

    // -----------------------------------------------------------------------
    // Holding register and handshake
    // -----------------------------------------------------------------------
    logic [7:0] hold_data_reg;
    logic       hold_pe_reg;
    logic       hold_fe_reg;
    logic       hold_bi_reg;
    logic       valid_reg;
    logic       oe_reg;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            hold_data_reg <= 8'd0;
            hold_pe_reg   <= 1'b0;
            hold_fe_reg   <= 1'b0;
            hold_bi_reg   <= 1'b0;
            valid_reg     <= 1'b0;
            oe_reg        <= 1'b0;
        end else begin
            oe_reg <= 1'b0;
            if (frame_done) begin
                // A register being drained this cycle counts as empty.
                if (!valid_reg || READY_I) begin
                    hold_data_reg <= shift_reg;
                    hold_pe_reg   <= pe_reg;
                    hold_fe_reg   <= fe_now;
                    hold_bi_reg   <= bi_now;
                    valid_reg     <= 1'b1;
                end else begin
                    oe_reg <= 1'b1;
                end
            end else if (valid_reg && READY_I) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign DATA_O  = hold_data_reg;
    assign PE_O    = hold_pe_reg;
    assign FE_O    = hold_fe_reg;
    assign BI_O    = hold_bi_reg;
    assign VALID_O = valid_reg;
    assign OE_O    = oe_reg;
    assign BUSY_O  = (state_reg != ST_IDLE);

endmodule
